// File: rtl/vga_pmod_monitor.sv
// rtl/vga_pmod_monitor.sv - receive-side raster timing checker and pixel probe for the TinyVGA PMOD bus
module vga_pmod_monitor #(
  parameter int unsigned H_TOTAL_CLK = 1600,
  parameter int unsigned H_SYNC_CLK  = 192,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LINE_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        vga_in,
  input  logic [CNT_W-1:0]  probe_x,
  input  logic [LINE_W-1:0] probe_y,
  input  logic              clear_err,
  output logic [CNT_W-1:0]  line_clks,
  output logic [CNT_W-1:0]  hsync_clks,
  output logic [LINE_W-1:0] frame_lines,
  output logic [LINE_W-1:0] vsync_lines,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              locked,
  output logic              err_h,
  output logic              err_v,
  output logic [5:0]        probe_rgb,
  output logic              probe_valid
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [CNT_W-1:0]  H_MAX     = '1;
  localparam logic [LINE_W-1:0] V_MAX     = '1;
  localparam logic [CNT_W-1:0]  H_TOTAL_W = CNT_W'(H_TOTAL_CLK);
  localparam logic [CNT_W-1:0]  H_SYNC_W  = CNT_W'(H_SYNC_CLK);
  localparam logic [LINE_W-1:0] V_TOTAL_W = LINE_W'(V_TOTAL);
  localparam logic [LINE_W-1:0] V_SYNC_W  = LINE_W'(V_SYNC);

  logic [7:0]        s1;
  logic              hs_d;
  logic              vs_d;
  logic              hs, vs;
  logic              hs_rise, hs_fall, vs_rise, vs_fall;
  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  h_meas;
  logic [LINE_W-1:0] v_cnt;
  state_t            state, state_nxt;
  logic              skip_line;
  logic              acq_bad;
  logic              probe_done;
  logic              probe_hit;
  logic              h_mis, v_mis;

  // Sync bits are active low on the pins; only their delayed copies are needed in the second stage.
  assign hs      = ~s1[7];
  assign vs      = ~s1[3];
  assign hs_rise = hs & ~hs_d;
  assign hs_fall = ~hs & hs_d;
  assign vs_rise = vs & ~vs_d;
  assign vs_fall = ~vs & vs_d;

  // h_cnt is 0 on the cycle after the assert edge, so the edge cycle is added back when measuring;
  // the same saturating value is the counter's next state.
  assign h_meas = (h_cnt == H_MAX) ? H_MAX : h_cnt + 1'b1;

  // The first line after entering LOCKED is exempt from the length check.
  assign h_mis = (hs_rise && (h_meas != H_TOTAL_W) && !((state == LOCKED) && skip_line))
               || (hs_fall && (h_meas != H_SYNC_W));
  assign v_mis = vs_rise && ((v_cnt != V_TOTAL_W) || (vsync_lines != V_SYNC_W));

  assign probe_hit = (h_cnt == probe_x) && (v_cnt == probe_y) && !probe_done;

  // Input register stage; reset to idle (syncs deasserted) so no edge is seen when reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 8'h88;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      s1   <= vga_in;
      hs_d <= hs;
      vs_d <= vs;
    end
  end

  // Horizontal clock counter with line length and hsync width capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt      <= '0;
      line_clks  <= '0;
      hsync_clks <= '0;
    end else begin
      if (hs_rise) begin
        line_clks <= h_meas;
        h_cnt     <= '0;
      end else begin
        h_cnt     <= h_meas;
      end
      if (hs_fall) hsync_clks <= h_meas;
    end
  end

  // Line counter with frame length and vsync width capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_cnt       <= '0;
      frame_lines <= '0;
      vsync_lines <= '0;
    end else begin
      if (vs_rise) begin
        frame_lines <= v_cnt;
        v_cnt       <= hs_rise ? LINE_W'(1) : '0;
      end else if (hs_rise && (v_cnt != V_MAX)) begin
        v_cnt       <= v_cnt + 1'b1;
      end
      if (vs_fall) vsync_lines <= v_cnt;
    end
  end

  // Frame pulse and wrapping frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= vs_rise;
      if (vs_rise) frame_count <= frame_count + 1'b1;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_nxt;
  end

  // Lock next-state: acquire on a vsync, lock after a clean frame, fall back on any mismatch.
  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (vs_rise) state_nxt = ACQUIRE;
      ACQUIRE:  if (vs_rise && !acq_bad && !h_mis && !v_mis) state_nxt = LOCKED;
      LOCKED:   if (h_mis || v_mis) state_nxt = ACQUIRE;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  // Lock outputs.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Frame-quality tracking while acquiring, and the first-line exemption after locking.
  // A mismatch that drops lock mid-frame taints the rest of that frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acq_bad   <= 1'b0;
      skip_line <= 1'b0;
    end else begin
      case (state)
        ACQUIRE: begin
          if (vs_rise)    acq_bad <= 1'b0;
          else if (h_mis) acq_bad <= 1'b1;
          skip_line <= (state_nxt == LOCKED);
        end
        LOCKED: begin
          if (h_mis || v_mis) acq_bad <= ~vs_rise;
          if (hs_rise) skip_line <= 1'b0;
        end
        default: begin
          acq_bad   <= 1'b0;
          skip_line <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_h <= 1'b0;
      err_v <= 1'b0;
    end else begin
      if ((state == LOCKED) && h_mis) err_h <= 1'b1;
      else if (clear_err)             err_h <= 1'b0;
      if ((state == LOCKED) && v_mis) err_v <= 1'b1;
      else if (clear_err)             err_v <= 1'b0;
    end
  end

  // Pixel probe: capture the colour once per line at the programmed coordinate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
      probe_done  <= 1'b0;
    end else begin
      probe_valid <= probe_hit;
      if (probe_hit) probe_rgb <= {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};
      probe_done <= hs_rise ? 1'b0 : (probe_done | probe_hit);
    end
  end

endmodule

// File: tb/tb_vga_pmod_monitor.sv
// tb/tb_vga_pmod_monitor.sv - self-checking bench for vga_pmod_monitor against an event-level raster model
module tb_vga_pmod_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  vga_in;
  logic [11:0] probe_x;
  logic [9:0]  probe_y;
  logic        clear_err;
  logic [11:0] line_clks, hsync_clks;
  logic [9:0]  frame_lines, vsync_lines;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        locked, err_h, err_v;
  logic [5:0]  probe_rgb;
  logic        probe_valid;

  vga_pmod_monitor #(
    .H_TOTAL_CLK(20), .H_SYNC_CLK(4), .V_TOTAL(6), .V_SYNC(2), .CNT_W(12), .LINE_W(10)
  ) dut (
    .clk(clk), .reset(reset), .vga_in(vga_in), .probe_x(probe_x), .probe_y(probe_y),
    .clear_err(clear_err), .line_clks(line_clks), .hsync_clks(hsync_clks),
    .frame_lines(frame_lines), .vsync_lines(vsync_lines), .frame_done(frame_done),
    .frame_count(frame_count), .locked(locked), .err_h(err_h), .err_v(err_v),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model state: events are indexed by the cycle in which the pin value sits in the first stage
  int          m_c, m_last_hr, m_v, m_st;
  bit          m_fired, m_skip, m_acq_bad;
  logic [7:0]  m_cur, m_prev;
  int          e_line, e_hsw, e_fl, e_vsl;
  bit          e_fd, e_lock, e_errh, e_errv, e_pv;
  logic [15:0] e_fc;
  logic [5:0]  e_prgb;
  int          pv_seen;
  logic [5:0]  pv_last;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_c = 0; m_last_hr = -1; m_v = 0; m_st = 0;
    m_fired = 0; m_skip = 0; m_acq_bad = 0;
    m_cur = 8'h88; m_prev = 8'h88;
    e_line = 0; e_hsw = 0; e_fl = 0; e_vsl = 0;
    e_fd = 0; e_lock = 0; e_errh = 0; e_errv = 0; e_pv = 0;
    e_fc = '0; e_prgb = '0;
  endtask

  // what the monitor must conclude about cycle m_c, from sync edge history
  task automatic model_eval(input bit clr);
    bit hr, hf, vr, vf, hit, hmis, vmis, seth, setv;
    int hc, meas, vc;
    hr = !m_cur[7] && m_prev[7];
    hf = m_cur[7] && !m_prev[7];
    vr = !m_cur[3] && m_prev[3];
    vf = m_cur[3] && !m_prev[3];
    meas = m_c - m_last_hr;
    if (meas > 4095) meas = 4095;
    hc = m_c - m_last_hr - 1;
    if (hc > 4095) hc = 4095;
    vc = m_v;
    hit = (hc == int'(probe_x)) && (vc == int'(probe_y)) && !m_fired;
    e_pv = hit;
    if (hit) e_prgb = {m_cur[0], m_cur[4], m_cur[1], m_cur[5], m_cur[2], m_cur[6]};
    m_fired = hr ? 1'b0 : (m_fired | hit);
    e_fd = vr;
    if (vr) e_fc = e_fc + 16'd1;
    hmis = (hr && meas != 20 && !(m_st == 2 && m_skip)) || (hf && meas != 4);
    vmis = vr && (vc != 6 || e_vsl != 2);
    if (hr) e_line = meas;
    if (hf) e_hsw = meas;
    if (vr) e_fl = vc;
    if (vf) e_vsl = vc;
    seth = (m_st == 2) && hmis;
    setv = (m_st == 2) && vmis;
    e_errh = seth ? 1'b1 : (clr ? 1'b0 : e_errh);
    e_errv = setv ? 1'b1 : (clr ? 1'b0 : e_errv);
    case (m_st)
      0: if (vr) begin m_st = 1; m_acq_bad = 0; end
      1: begin
        if (vr) begin
          if (!m_acq_bad && !hmis && !vmis) begin m_st = 2; m_skip = 1; end
          m_acq_bad = 0;
        end else if (hmis) m_acq_bad = 1;
      end
      default: begin
        if (hmis || vmis) begin m_st = 1; m_acq_bad = !vr; end
        if (hr) m_skip = 0;
      end
    endcase
    e_lock = (m_st == 2);
    if (vr) m_v = hr ? 1 : 0;
    else if (hr && m_v < 1023) m_v++;
    if (hr) m_last_hr = m_c;
  endtask

  task automatic compare_outputs();
    chk("line_clks", int'(line_clks), e_line);
    chk("hsync_clks", int'(hsync_clks), e_hsw);
    chk("frame_lines", int'(frame_lines), e_fl);
    chk("vsync_lines", int'(vsync_lines), e_vsl);
    chk("frame_done", int'(frame_done), int'(e_fd));
    chk("frame_count", int'(frame_count), int'(e_fc));
    chk("locked", int'(locked), int'(e_lock));
    chk("err_h", int'(err_h), int'(e_errh));
    chk("err_v", int'(err_v), int'(e_errv));
    chk("probe_valid", int'(probe_valid), int'(e_pv));
    chk("probe_rgb", int'(probe_rgb), int'(e_prgb));
  endtask

  task automatic step(input logic [7:0] v);
    bit clr;
    vga_in = v;
    clr = clear_err;
    @(posedge clk); #1;
    model_eval(clr);
    m_prev = m_cur; m_cur = v; m_c++;
    compare_outputs();
    if (probe_valid) begin pv_seen++; pv_last = probe_rgb; end
  endtask

  // one line: hsync active for the first hsw clocks; probe pixel forced at offset 11
  task automatic send_line(input int len, input int hsw, input bit vs_on, input bit probe_line, input bit clr1);
    logic [7:0] v;
    for (int i = 0; i < len; i++) begin
      v = 8'($urandom) & 8'h77;
      if (i >= hsw) v[7] = 1'b1;
      if (!vs_on) v[3] = 1'b1;
      if (probe_line && i == 11) v = (v & 8'h88) | 8'h63;
      clear_err = clr1 && (i == 1);
      step(v);
    end
    clear_err = 1'b0;
  endtask

  task automatic send_frame(input int first, input int last, input int vsl, input int stretch, input int clr_line);
    for (int l = first; l <= last; l++)
      send_line((l == stretch) ? 21 : 20, 4, l < vsl, l == 2, l == clr_line);
  endtask

  task automatic fresh_start();
    send_line(20, 4, 0, 0, 0);
    send_line(20, 4, 0, 0, 0);
    send_frame(0, 5, 2, -1, -1);
    send_frame(0, 5, 2, -1, -1);
    send_frame(0, 5, 2, -1, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vga_in = 8'h88; clear_err = 1'b0;
    probe_x = 12'd10; probe_y = 10'd3;
    pv_seen = 0; pv_last = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset line_clks", int'(line_clks), 0);
    chk("reset frame_count", int'(frame_count), 0);
    chk("reset locked", int'(locked), 0);
    chk("reset err_h", int'(err_h), 0);
    chk("reset probe_valid", int'(probe_valid), 0);
    @(negedge clk) reset = 1'b0;

    // nominal raster
    send_line(20, 4, 0, 0, 0);
    send_line(20, 4, 0, 0, 0);
    send_frame(0, 5, 2, -1, -1);
    chk("lock before 2nd vsync", int'(locked), 0);
    send_frame(0, 0, 2, -1, -1);
    chk("lock at 2nd vsync", int'(locked), 1);
    send_frame(1, 5, 2, -1, -1);
    pv_seen = 0;
    send_frame(0, 5, 2, -1, -1);
    chk("probe pulses per frame", pv_seen, 1);
    chk("probe colour", int'(pv_last), int'(6'b101101));
    chk("nominal line_clks", int'(line_clks), 20);
    chk("nominal hsync_clks", int'(hsync_clks), 4);
    chk("nominal frame_lines", int'(frame_lines), 6);
    chk("nominal vsync_lines", int'(vsync_lines), 2);
    chk("nominal frame_count", int'(frame_count), 3);
    chk("nominal locked", int'(locked), 1);
    chk("nominal err_h", int'(err_h), 0);
    chk("nominal err_v", int'(err_v), 0);

    // stretched line, relock, clear
    send_frame(0, 5, 2, 3, -1);
    chk("stretch err_h", int'(err_h), 1);
    chk("stretch locked", int'(locked), 0);
    chk("stretch line_clks", int'(line_clks), 20);
    send_frame(0, 0, 2, -1, -1);
    chk("tainted frame no relock", int'(locked), 0);
    send_frame(1, 5, 2, -1, -1);
    send_frame(0, 0, 2, -1, -1);
    chk("relock", int'(locked), 1);
    chk("err_h sticky", int'(err_h), 1);
    send_frame(1, 5, 2, -1, 3);
    chk("err_h cleared", int'(err_h), 0);

    // long frame
    send_frame(0, 6, 2, -1, -1);
    send_frame(0, 0, 2, -1, -1);
    chk("long frame_lines", int'(frame_lines), 7);
    chk("long err_v", int'(err_v), 1);
    chk("long locked", int'(locked), 0);
    send_frame(1, 5, 2, -1, -1);
    send_frame(0, 5, 2, -1, -1);
    chk("relock after long", int'(locked), 1);

    // clear in the same cycle as a new mismatch
    send_frame(0, 5, 2, 3, 4);
    chk("set beats clear err_h", int'(err_h), 1);
    chk("clear err_v", int'(err_v), 0);

    // randomized raster with occasional timing faults and clears
    for (int f = 0; f < 25; f++) begin
      int nl, vsl, len, hw;
      nl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 7)) : 6;
      vsl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 2;
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(19, 21)) : 20;
        hw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 5)) : 4;
        send_line(len, hw, l < vsl, l == 2, $urandom_range(0, 15) == 0);
      end
    end

    // asynchronous reset in the middle of a line
    send_frame(0, 5, 2, -1, -1);
    for (int i = 0; i < 7; i++) step((i < 4) ? 8'h08 : 8'h88);
    #2 reset = 1'b1;
    #1;
    chk("async line_clks", int'(line_clks), 0);
    chk("async hsync_clks", int'(hsync_clks), 0);
    chk("async frame_lines", int'(frame_lines), 0);
    chk("async vsync_lines", int'(vsync_lines), 0);
    chk("async frame_count", int'(frame_count), 0);
    chk("async locked", int'(locked), 0);
    chk("async err_h", int'(err_h), 0);
    chk("async err_v", int'(err_v), 0);
    chk("async probe_rgb", int'(probe_rgb), 0);
    chk("async probe_valid", int'(probe_valid), 0);
    chk("async frame_done", int'(frame_done), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    fresh_start();
    chk("post-reset locked", int'(locked), 1);
    chk("post-reset frame_count", int'(frame_count), 3);
    chk("post-reset err_h", int'(err_h), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
